// File: rtl/chronos_pkg.sv
// Shared chronos types and constants used by the per-tile debug path.
package chronos;

  typedef logic [15:0][31:0] cache_line_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    STREAM = 3'd2,
    PAD    = 3'd3,
    DRAIN  = 3'd4
  } debug_route_state_t;

  localparam logic [31:0] DEBUG_FILL_WORD      = 32'hDEAD_BEEF;
  localparam int          DEBUG_TIMEOUT_CYCLES = 1024;

  // Saturating error counter increment; several error events can land in one cycle.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/tile_debug_router.sv
// Routes one tile debug read to an in-tile component and always returns exactly
// arlen+1 beats upstream, padding or draining when the component misbehaves.
module tile_debug_router
  import chronos::*;
#(
  parameter int          N_COMP         = 16,
  parameter int          TIMEOUT_CYCLES = DEBUG_TIMEOUT_CYCLES,
  parameter logic [31:0] FILL_WORD      = DEBUG_FILL_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_arvalid,
  input  logic [7:0]               up_arlen,
  input  logic [7:0]               up_comp,
  input  logic                     up_rready,
  output cache_line_t              up_rdata,
  output logic                     up_rvalid,
  output logic                     up_rlast,
  output logic [N_COMP-1:0]        comp_arvalid,
  output logic [7:0]               comp_arlen,
  output logic [N_COMP-1:0]        comp_rready,
  input  cache_line_t [N_COMP-1:0] comp_rdata,
  input  logic [N_COMP-1:0]        comp_rvalid,
  input  logic [N_COMP-1:0]        comp_rlast,
  output logic                     busy,
  output logic [15:0]              err_count
);

  localparam int               SEL_W    = (N_COMP > 1) ? $clog2(N_COMP) : 1;
  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      N_COMP_U = 32'(N_COMP);

  debug_route_state_t state_r, state_nxt_s;
  logic [SEL_W-1:0]   sel_r, sel_nxt_s;
  logic [7:0]         comp_arlen_r, arlen_nxt_s;
  logic [8:0]         beats_left_r, beats_nxt_s;
  logic [TMR_W-1:0]   timer_r, timer_nxt_s;
  logic [15:0]        err_count_r;
  logic [1:0]         err_inc_s;
  logic               fsm_err_s;
  logic               ignored_req_s;
  logic               comp_ok_s;

  logic               sel_rvalid_s;
  logic               sel_rlast_s;
  cache_line_t        sel_rdata_s;

  cache_line_t        up_rdata_s;
  logic               up_rvalid_s;
  logic               up_rlast_s;
  logic [N_COMP-1:0]  comp_arvalid_s;
  logic [N_COMP-1:0]  comp_rready_s;

  assign comp_ok_s     = ({24'd0, up_comp} < N_COMP_U);
  assign sel_rvalid_s  = comp_rvalid[sel_r];
  assign sel_rlast_s   = comp_rlast[sel_r];
  assign sel_rdata_s   = comp_rdata[sel_r];
  assign ignored_req_s = up_arvalid && (state_r != IDLE);
  assign err_inc_s     = {1'b0, ignored_req_s} + {1'b0, fsm_err_s};

  // Next-state, counters and data-path muxing for the routing FSM.
  always_comb begin
    state_nxt_s    = state_r;
    sel_nxt_s      = sel_r;
    arlen_nxt_s    = comp_arlen_r;
    beats_nxt_s    = beats_left_r;
    timer_nxt_s    = timer_r;
    fsm_err_s      = 1'b0;
    up_rdata_s     = '0;
    up_rvalid_s    = 1'b0;
    up_rlast_s     = 1'b0;
    comp_arvalid_s = '0;
    comp_rready_s  = '0;

    case (state_r)
      IDLE: begin
        if (up_arvalid) begin
          sel_nxt_s   = up_comp[SEL_W-1:0];
          arlen_nxt_s = up_arlen;
          beats_nxt_s = {1'b0, up_arlen} + 9'd1;
          if (comp_ok_s) begin
            state_nxt_s = ISSUE;
          end else begin
            state_nxt_s = PAD;
            fsm_err_s   = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      ISSUE: begin
        comp_arvalid_s[sel_r] = 1'b1;
        state_nxt_s           = STREAM;
      end

      STREAM: begin
        up_rdata_s           = sel_rdata_s;
        up_rvalid_s          = sel_rvalid_s;
        up_rlast_s           = sel_rvalid_s && (beats_left_r == 9'd1);
        comp_rready_s[sel_r] = up_rready;
        if (sel_rvalid_s && up_rready) begin
          beats_nxt_s = beats_left_r - 9'd1;
          timer_nxt_s = '0;
          if (beats_left_r == 9'd1) begin
            if (sel_rlast_s) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = DRAIN;
              fsm_err_s   = 1'b1;
            end
          end else if (sel_rlast_s) begin
            state_nxt_s = PAD;
            fsm_err_s   = 1'b1;
          end else begin
            state_nxt_s = STREAM;
          end
        end else if (!sel_rvalid_s) begin
          if (timer_r == TMR_LAST) begin
            state_nxt_s = PAD;
            fsm_err_s   = 1'b1;
          end else begin
            timer_nxt_s = timer_r + TMR_ONE;
          end
        end else begin
          timer_nxt_s = timer_r;
        end
      end

      PAD: begin
        up_rdata_s  = {16{FILL_WORD}};
        up_rvalid_s = 1'b1;
        up_rlast_s  = (beats_left_r == 9'd1);
        if (up_rready) begin
          beats_nxt_s = beats_left_r - 9'd1;
          state_nxt_s = (beats_left_r == 9'd1) ? IDLE : PAD;
        end else begin
          beats_nxt_s = beats_left_r;
        end
      end

      DRAIN: begin
        comp_rready_s[sel_r] = 1'b1;
        if (sel_rvalid_s && sel_rlast_s) begin
          state_nxt_s = IDLE;
        end else if (timer_r == TMR_LAST) begin
          state_nxt_s = IDLE;
          fsm_err_s   = 1'b1;
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Every state change restarts the idle timer.
    if (state_nxt_s != state_r) begin
      timer_nxt_s = '0;
    end else begin
      timer_nxt_s = timer_nxt_s;
    end
  end

  // State, request latches, counters and saturating error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      sel_r        <= '0;
      comp_arlen_r <= 8'd0;
      beats_left_r <= 9'd0;
      timer_r      <= '0;
      err_count_r  <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      sel_r        <= sel_nxt_s;
      comp_arlen_r <= arlen_nxt_s;
      beats_left_r <= beats_nxt_s;
      timer_r      <= timer_nxt_s;
      err_count_r  <= sat_add16(err_count_r, err_inc_s);
    end
  end

  assign up_rdata     = up_rdata_s;
  assign up_rvalid    = up_rvalid_s;
  assign up_rlast     = up_rlast_s;
  assign comp_arvalid = comp_arvalid_s;
  assign comp_rready  = comp_rready_s;
  assign comp_arlen   = comp_arlen_r;
  assign busy         = (state_r != IDLE);
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_tile_debug_router.sv
// Randomized scoreboard bench for tile_debug_router with behavioural components.
module tb_tile_debug_router;
  import chronos::*;

  localparam int NC = 16;
  localparam int TO = 16;

  typedef struct packed {
    logic        last;
    cache_line_t data;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               up_arvalid;
  logic [7:0]         up_arlen;
  logic [7:0]         up_comp;
  logic               up_rready;
  cache_line_t        up_rdata;
  logic               up_rvalid;
  logic               up_rlast;
  logic [NC-1:0]      comp_arvalid;
  logic [7:0]         comp_arlen;
  logic [NC-1:0]      comp_rready;
  cache_line_t [NC-1:0] comp_rdata;
  logic [NC-1:0]      comp_rvalid;
  logic [NC-1:0]      comp_rlast;
  logic               busy;
  logic [15:0]        err_count;

  int          checks = 0;
  int          errors = 0;
  int          exp_err = 0;
  int          arv_total = 0;
  int          ready_mode = 0;
  beat_t       exp_q[$];
  cache_line_t cdata [0:299];
  cache_line_t fill_line;

  tile_debug_router #(.N_COMP(NC), .TIMEOUT_CYCLES(TO), .FILL_WORD(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .up_arvalid(up_arvalid), .up_arlen(up_arlen), .up_comp(up_comp), .up_rready(up_rready),
    .up_rdata(up_rdata), .up_rvalid(up_rvalid), .up_rlast(up_rlast),
    .comp_arvalid(comp_arvalid), .comp_arlen(comp_arlen), .comp_rready(comp_rready),
    .comp_rdata(comp_rdata), .comp_rvalid(comp_rvalid), .comp_rlast(comp_rlast),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Upstream ready pattern: always ready, random, or toggling.
  initial begin
    up_rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       up_rready = 1'b1;
        1:       up_rready = 1'($urandom_range(0, 1));
        default: up_rready = ~up_rready;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every upstream handshake and checks hold stability.
  initial begin
    bit          pend;
    cache_line_t pdata;
    beat_t       e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        arv_total += $countones(comp_arvalid);
        if (pend) begin
          chk("hold_valid", up_rvalid, 1);
          chk("hold_data", up_rdata, pdata);
        end
        if (up_rvalid && up_rready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=beat required=none");
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", up_rdata, e.data);
            chk("beat_last", up_rlast, e.last);
          end
        end
        pend  = up_rvalid && !up_rready;
        pdata = up_rdata;
      end
    end
  end

  // Behavioural component: returns nb beats, rlast on the last, random gaps.
  task automatic drive_comp(input int c, input int nb);
    int guard;
    bit acc;
    @(posedge clk); #1;
    for (int b = 0; b < nb; b++) begin
      comp_rvalid[c] = 1'b0;
      comp_rlast[c]  = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      comp_rvalid[c] = 1'b1;
      comp_rdata[c]  = cdata[b];
      comp_rlast[c]  = (b == nb - 1);
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 3000) begin
        @(negedge clk);
        acc = comp_rready[c];
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL comp_accept_timeout actual=no_ready required=ready comp=%0d", c);
        break;
      end
    end
    comp_rvalid[c] = 1'b0;
    comp_rlast[c]  = 1'b0;
  endtask

  // One transaction: model the expected upstream stream, then issue and wait for idle.
  task automatic run_txn(input int c, input int arlen, input int nb, input bit inject);
    int          n_up;
    bit          valid;
    int          cyc;
    int          first_v;
    logic [15:0] exp_arv;
    beat_t       e;
    valid = (c < NC);
    n_up  = arlen + 1;
    for (int b = 0; b < nb; b++)
      for (int w = 0; w < 16; w++) cdata[b][w] = $urandom;
    for (int i = 0; i < n_up; i++) begin
      e.last = (i == n_up - 1);
      e.data = (valid && i < nb) ? cdata[i] : fill_line;
      exp_q.push_back(e);
    end
    if (!valid || nb != n_up) exp_err++;

    @(posedge clk); #1;
    arv_total  = 0;
    up_arvalid = 1'b1;
    up_comp    = 8'(c);
    up_arlen   = 8'(arlen);
    @(posedge clk); #1;
    up_arvalid = 1'b0;
    up_comp    = 8'($urandom);
    up_arlen   = 8'($urandom);
    @(negedge clk);
    exp_arv = valid ? (16'd1 << c) : 16'd0;
    chk("issue_arvalid", comp_arvalid, exp_arv);
    chk("busy_after_req", busy, 1);
    if (valid) chk("issue_arlen", comp_arlen, arlen);

    cyc     = 0;
    first_v = -1;
    fork
      if (valid && nb > 0) drive_comp(c, nb);
      begin
        while (busy && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          if (first_v < 0 && up_rvalid) first_v = cyc;
          if (inject && cyc == 3 && busy) begin
            up_arvalid = 1'b1;
            exp_err++;
          end else begin
            up_arvalid = 1'b0;
          end
        end
      end
    join
    up_arvalid = 1'b0;
    if (cyc >= 5000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle comp=%0d", c);
    end
    chk("beats_remaining", exp_q.size(), 0);
    chk("err_count", err_count, exp_err);
    chk("arvalid_pulses", arv_total, valid ? 1 : 0);
    if (valid && nb == 0) chk("timeout_latency", first_v, TO + 1);
    exp_q.delete();
  endtask

  initial begin
    int c, arlen, nb, kind;
    for (int w = 0; w < 16; w++) fill_line[w] = 32'hDEAD_BEEF;
    rst         = 1'b1;
    up_arvalid  = 1'b0;
    up_arlen    = 8'd0;
    up_comp     = 8'd0;
    comp_rdata  = '0;
    comp_rvalid = '0;
    comp_rlast  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", up_rvalid, 0);
    chk("rst_rlast", up_rlast, 0);
    chk("rst_rdata", up_rdata, 0);
    chk("rst_arvalid", comp_arvalid, 0);
    chk("rst_rready", comp_rready, 0);
    chk("rst_arlen", comp_arlen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;

    ready_mode = 0; run_txn(3, 3, 4, 1'b0);
    ready_mode = 0; run_txn(20, 1, 0, 1'b0);
    ready_mode = 1; run_txn(7, 7, 3, 1'b0);
    ready_mode = 1; run_txn(2, 1, 5, 1'b0);
    ready_mode = 2; run_txn(9, 0, 0, 1'b1);
    ready_mode = 0; run_txn(15, 255, 256, 1'b0);
    ready_mode = 1; run_txn(16, 0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      c     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 255)) : int'($urandom_range(0, 15));
      arlen = $urandom_range(0, 7);
      kind  = $urandom_range(0, 3);
      case (kind)
        0:       nb = arlen + 1;
        1:       nb = (arlen > 0) ? int'($urandom_range(1, arlen)) : arlen + 1;
        2:       nb = arlen + 1 + int'($urandom_range(1, 4));
        default: nb = 0;
      endcase
      ready_mode = $urandom_range(0, 2);
      run_txn(c, arlen, nb, 1'($urandom_range(0, 1)) && (nb == 0));
    end

    // Reset in the middle of a transaction to a mute component.
    ready_mode = 0;
    @(posedge clk); #1;
    up_arvalid = 1'b1;
    up_comp    = 8'd5;
    up_arlen   = 8'd2;
    @(posedge clk); #1;
    up_arvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rvalid", up_rvalid, 0);
    chk("midrst_rlast", up_rlast, 0);
    chk("midrst_rdata", up_rdata, 0);
    chk("midrst_rready", comp_rready, 0);
    chk("midrst_arvalid", comp_arvalid, 0);
    chk("midrst_arlen", comp_arlen, 0);
    chk("midrst_err", err_count, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_err = 0;
    run_txn(1, 2, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
